// File: rtl/buffer_out_squeeze.sv
// Keccak squeeze-side output buffer: streams the digest/XOF words from the captured rate lanes.
// Define SHAKE_MULTI_SQUEEZE_EN for multi-block XOF output (WAIT_SQZ state, squeeze_req).
module buffer_out_squeeze #(
  parameter int unsigned DW     = 64,
  parameter int unsigned RATE_W = 1344,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        cmode,
  input  logic [LEN_W-1:0]  out_len,
  input  logic [RATE_W-1:0] state_i,
  input  logic              state_valid,
  output logic [DW-1:0]     dt_o,
  output logic [DW/8-1:0]   dt_keep,
  output logic              dt_valid,
  output logic              dt_last,
  input  logic              dt_ready,
  output logic              squeeze_req,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NumLanes = RATE_W / DW;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSend    = 2'd1;
`ifdef SHAKE_MULTI_SQUEEZE_EN
  localparam logic [1:0] StWaitSqz = 2'd2;
`endif

  localparam logic [2:0] ModeSha224   = 3'd0;
  localparam logic [2:0] ModeSha256   = 3'd1;
  localparam logic [2:0] ModeSha384   = 3'd2;
  localparam logic [2:0] ModeSha512   = 3'd3;
  localparam logic [2:0] ModeShake128 = 3'd4;
  localparam logic [2:0] ModeShake256 = 3'd5;

  // Rate in 64-bit words; SHA3 digests never reach the block end, so they share the widest rate.
  function automatic logic [4:0] rate_words(input logic [2:0] mode);
    rate_words = (mode == ModeShake256) ? 5'd17 : 5'd21;
  endfunction

  logic [1:0]        fsm_q, fsm_d;
  logic [2:0]        mode_q, mode_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [4:0]        blk_idx_q, blk_idx_d;
  logic [RATE_W-1:0] state_q, state_d;
  logic              done_q, done_d;
`ifdef SHAKE_MULTI_SQUEEZE_EN
  logic              sqz_q, sqz_d;
`endif

  logic [2:0]       mode_in;
  logic [LEN_W-1:0] xof_len;
  logic [LEN_W-1:0] total_in;

  always_comb begin
    mode_in = (cmode > ModeShake256) ? ModeSha256 : cmode;
    xof_len = (out_len == '0) ? LEN_W'(1) : out_len;
`ifndef SHAKE_MULTI_SQUEEZE_EN
    if (xof_len > LEN_W'(rate_words(mode_in))) xof_len = LEN_W'(rate_words(mode_in));
`endif
    case (mode_in)
      ModeSha224, ModeSha256: total_in = LEN_W'(4);
      ModeSha384:             total_in = LEN_W'(6);
      ModeSha512:             total_in = LEN_W'(8);
      default:                total_in = xof_len;
    endcase
  end

  always_comb begin
    fsm_d     = fsm_q;
    mode_d    = mode_q;
    rem_d     = rem_q;
    blk_idx_d = blk_idx_q;
    state_d   = state_q;
    done_d    = 1'b0;
`ifdef SHAKE_MULTI_SQUEEZE_EN
    sqz_d     = 1'b0;
`endif
    case (fsm_q)
      StIdle: begin
        if (state_valid) begin
          fsm_d     = StSend;
          mode_d    = mode_in;
          rem_d     = total_in;
          blk_idx_d = '0;
          state_d   = state_i;
        end
      end
      StSend: begin
        if (dt_ready) begin
          rem_d     = rem_q - LEN_W'(1);
          blk_idx_d = blk_idx_q + 5'd1;
          if (rem_q == LEN_W'(1)) begin
            fsm_d     = StIdle;
            blk_idx_d = '0;
            done_d    = 1'b1;
          end
`ifdef SHAKE_MULTI_SQUEEZE_EN
          else if (blk_idx_q == rate_words(mode_q) - 5'd1) begin
            fsm_d = StWaitSqz;
            sqz_d = 1'b1;
          end
`endif
        end
      end
`ifdef SHAKE_MULTI_SQUEEZE_EN
      StWaitSqz: begin
        // Only the lanes are refreshed; mode and remaining length carry over.
        if (state_valid) begin
          fsm_d     = StSend;
          blk_idx_d = '0;
          state_d   = state_i;
        end
      end
`endif
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= StIdle;
      mode_q    <= '0;
      rem_q     <= '0;
      blk_idx_q <= '0;
      state_q   <= '0;
      done_q    <= 1'b0;
`ifdef SHAKE_MULTI_SQUEEZE_EN
      sqz_q     <= 1'b0;
`endif
    end else begin
      fsm_q     <= fsm_d;
      mode_q    <= mode_d;
      rem_q     <= rem_d;
      blk_idx_q <= blk_idx_d;
      state_q   <= state_d;
      done_q    <= done_d;
`ifdef SHAKE_MULTI_SQUEEZE_EN
      sqz_q     <= sqz_d;
`endif
    end
  end

  logic [DW-1:0] lanes [NumLanes];
  logic [DW-1:0] lane;
  logic [DW-1:0] lane_rev;

  always_comb begin
    for (int k = 0; k < NumLanes; k++) lanes[k] = state_q[k*DW +: DW];
    lane = lanes[blk_idx_q];
    for (int b = 0; b < DW / 8; b++) lane_rev[DW-1-8*b -: 8] = lane[8*b +: 8];
  end

  always_comb begin
    dt_valid = (fsm_q == StSend);
    busy     = (fsm_q != StIdle);
    dt_last  = dt_valid && (rem_q == LEN_W'(1));
    dt_o     = dt_valid ? lane_rev : '0;
    if (!dt_valid)                             dt_keep = '0;
    else if (dt_last && mode_q == ModeSha224)  dt_keep = 8'hF0;
    else                                       dt_keep = 8'hFF;
    done     = done_q;
`ifdef SHAKE_MULTI_SQUEEZE_EN
    squeeze_req = sqz_q;
`else
    squeeze_req = 1'b0;
`endif
  end

endmodule

// File: tb/tb_buffer_out_squeeze.sv
// Directed bench for buffer_out_squeeze; follows SHAKE_MULTI_SQUEEZE_EN for the XOF scenario.
module tb_buffer_out_squeeze;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    cmode = '0;
  logic [15:0]   out_len = '0;
  logic [1343:0] state_i = '0;
  logic          state_valid = 1'b0;
  logic [63:0]   dt_o;
  logic [7:0]    dt_keep;
  logic          dt_valid, dt_last, squeeze_req, busy, done;
  logic          dt_ready = 1'b1;

  always #5 clk = ~clk;

  buffer_out_squeeze dut (
    .clk(clk), .rst_n(rst_n), .cmode(cmode), .out_len(out_len), .state_i(state_i),
    .state_valid(state_valid), .dt_o(dt_o), .dt_keep(dt_keep), .dt_valid(dt_valid),
    .dt_last(dt_last), .dt_ready(dt_ready), .squeeze_req(squeeze_req), .busy(busy), .done(done)
  );

  int checks = 0;
  int failures = 0;

  logic [1343:0] blk1, blk2;
  logic [63:0]   w_q[$];
  logic [7:0]    k_q[$];
  logic          l_q[$];
  int            n_done, n_sqz, n_sqz_bad, n_both, n_stall_bad;
  bit            first_ok, finished;
  logic          busy_end;

  // Lane k of blk1 holds bytes 8k..8k+7 little-endian, so word k streams them ascending.
  function automatic logic [63:0] exp_word(input int k);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[63-8*b -: 8] = 8'(8 * k + b);
    return w;
  endfunction

  task automatic run_stream(input logic [2:0] mode, input logic [15:0] len, input int ready_mode);
    logic stall;
    logic [63:0] po;
    logic [7:0] pk;
    logic pl;
    w_q.delete(); k_q.delete(); l_q.delete();
    n_done = 0; n_sqz = 0; n_sqz_bad = 0; n_both = 0; n_stall_bad = 0;
    first_ok = 0; finished = 0; busy_end = 1'bx;
    stall = 1'b0; po = '0; pk = '0; pl = 1'b0;
    @(negedge clk);
    cmode = mode; out_len = len; state_i = blk1; state_valid = 1'b1; dt_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      state_valid = 1'b0;
      if (c == 0) begin
        first_ok = dt_valid;
        cmode = 3'd7;
        out_len = 16'hFFFF;
      end
      if (stall && !(dt_valid && dt_o == po && dt_keep == pk && dt_last == pl)) n_stall_bad++;
      if (done && squeeze_req) n_both++;
      if (done) begin
        n_done++;
        busy_end = busy;
        finished = 1;
        break;
      end
      if (squeeze_req) begin
        n_sqz++;
        if (dt_valid || !busy) n_sqz_bad++;
        state_i = blk2;
        state_valid = 1'b1;
      end
      dt_ready = (ready_mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      stall = dt_valid && !dt_ready;
      po = dt_o; pk = dt_keep; pl = dt_last;
      if (dt_valid && dt_ready) begin
        w_q.push_back(dt_o);
        k_q.push_back(dt_keep);
        l_q.push_back(dt_last);
      end
    end
    dt_ready = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({dt_valid, dt_last, busy, done, squeeze_req} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00000", {dt_valid, dt_last, busy, done, squeeze_req});
    end
    checks++;
    if (dt_o !== 64'h0) begin failures++; $display("FAIL reset_dt_o got=%h want=0", dt_o); end
    checks++;
    if (dt_keep !== 8'h00) begin failures++; $display("FAIL reset_keep got=%h want=00", dt_keep); end
    rst_n = 1'b1;
  endtask

  task automatic test_sha3_256;
    run_stream(3'd1, 16'd0, 0);
    checks++;
    if (!finished) begin failures++; $display("FAIL s256_timeout got=no_done want=done"); end
    checks++;
    if (!first_ok) begin failures++; $display("FAIL s256_latency got=0 want=dt_valid"); end
    checks++;
    if (w_q.size() != 4) begin failures++; $display("FAIL s256_count got=%0d want=4", w_q.size()); end
    checks++;
    if (w_q.size() > 0 && w_q[0] !== 64'h0001020304050607) begin
      failures++; $display("FAIL s256_word0 got=%h want=0001020304050607", w_q[0]);
    end
    for (int k = 0; k < w_q.size(); k++) begin
      checks++;
      if (w_q[k] !== exp_word(k) || k_q[k] !== 8'hFF || l_q[k] !== (k == 3)) begin
        failures++;
        $display("FAIL s256_w%0d got=%h/%h/%b want=%h/ff/%b", k, w_q[k], k_q[k], l_q[k],
                 exp_word(k), (k == 3));
      end
    end
    checks++;
    if (n_done != 1 || busy_end !== 1'b0) begin
      failures++; $display("FAIL s256_done got=%0d busy=%b want=1 busy=0", n_done, busy_end);
    end
    checks++;
    if (n_sqz != 0) begin failures++; $display("FAIL s256_sqz got=%0d want=0", n_sqz); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL s256_after got=%b%b want=00", done, busy);
    end
  endtask

  task automatic test_sha3_224;
    logic [7:0] keep_exp [4];
    keep_exp[0] = 8'hFF; keep_exp[1] = 8'hFF; keep_exp[2] = 8'hFF; keep_exp[3] = 8'hF0;
    run_stream(3'd0, 16'd0, 0);
    checks++;
    if (w_q.size() != 4) begin failures++; $display("FAIL s224_count got=%0d want=4", w_q.size()); end
    for (int k = 0; k < w_q.size() && k < 4; k++) begin
      checks++;
      if (k_q[k] !== keep_exp[k] || l_q[k] !== (k == 3)) begin
        failures++;
        $display("FAIL s224_keep%0d got=%h/%b want=%h/%b", k, k_q[k], l_q[k], keep_exp[k], (k == 3));
      end
    end
  endtask

  task automatic test_mode_alias;
    run_stream(3'd6, 16'd9, 0);
    checks++;
    if (w_q.size() != 4) begin failures++; $display("FAIL mode6_count got=%0d want=4", w_q.size()); end
    run_stream(3'd2, 16'd0, 0);
    checks++;
    if (w_q.size() != 6 || l_q[5] !== 1'b1 || l_q[4] !== 1'b0) begin
      failures++; $display("FAIL s384_count got=%0d want=6 with last on 6th", w_q.size());
    end
  endtask

  task automatic test_stall;
    run_stream(3'd3, 16'd0, 1);
    checks++;
    if (w_q.size() != 8) begin failures++; $display("FAIL stall_count got=%0d want=8", w_q.size()); end
    checks++;
    if (n_stall_bad != 0) begin
      failures++; $display("FAIL stall_hold got=%0d unstable want=0", n_stall_bad);
    end
    for (int k = 0; k < w_q.size(); k++) begin
      checks++;
      if (w_q[k] !== exp_word(k) || l_q[k] !== (k == 7)) begin
        failures++;
        $display("FAIL stall_w%0d got=%h/%b want=%h/%b", k, w_q[k], l_q[k], exp_word(k), (k == 7));
      end
    end
  endtask

  task automatic test_shake128;
    int n_exp;
    logic [63:0] e;
    run_stream(3'd4, 16'd30, 0);
`ifdef SHAKE_MULTI_SQUEEZE_EN
    n_exp = 30;
    checks++;
    if (n_sqz != 1 || n_sqz_bad != 0 || n_both != 0) begin
      failures++;
      $display("FAIL shk128_sqz got=%0d/%0d/%0d want=1/0/0", n_sqz, n_sqz_bad, n_both);
    end
`else
    n_exp = 21;
    checks++;
    if (n_sqz != 0) begin failures++; $display("FAIL shk128_sqz got=%0d want=0", n_sqz); end
`endif
    checks++;
    if (w_q.size() != n_exp) begin
      failures++; $display("FAIL shk128_count got=%0d want=%0d", w_q.size(), n_exp);
    end
    for (int k = 0; k < w_q.size(); k++) begin
      e = (k < 21) ? exp_word(k) : (exp_word(k - 21) ^ {8{8'hA5}});
      checks++;
      if (w_q[k] !== e || l_q[k] !== (k == n_exp - 1)) begin
        failures++;
        $display("FAIL shk128_w%0d got=%h/%b want=%h/%b", k, w_q[k], l_q[k], e, (k == n_exp - 1));
      end
    end
  endtask

  task automatic test_shake256;
    run_stream(3'd5, 16'd17, 0);
    checks++;
    if (w_q.size() != 17 || n_sqz != 0 || n_done != 1) begin
      failures++;
      $display("FAIL shk256_17 got=%0d sqz=%0d done=%0d want=17 sqz=0 done=1", w_q.size(), n_sqz, n_done);
    end
    checks++;
    if (w_q.size() == 17 && (l_q[16] !== 1'b1 || l_q[15] !== 1'b0 || w_q[16] !== exp_word(16))) begin
      failures++; $display("FAIL shk256_last got=%b%b want=01", l_q[15], l_q[16]);
    end
    run_stream(3'd5, 16'd0, 0);
    checks++;
    if (w_q.size() != 1 || l_q[0] !== 1'b1 || w_q[0] !== 64'h0001020304050607) begin
      failures++; $display("FAIL shk256_len0 got=%0d words want=1 with last", w_q.size());
    end
  endtask

  task automatic test_abort;
    @(negedge clk);
    cmode = 3'd3; state_i = blk1; state_valid = 1'b1; dt_ready = 1'b1;
    @(negedge clk);
    state_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dt_o !== exp_word(2)) begin failures++; $display("FAIL abort_pre got=%h want=%h", dt_o, exp_word(2)); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dt_valid, busy, done, dt_last} !== 4'b0 || dt_o !== 64'h0) begin
      failures++; $display("FAIL abort_async got=%b%b%b%b want=0000", dt_valid, busy, done, dt_last);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_nodone got=%b%b want=00", done, busy);
    end
    rst_n = 1'b1;
    run_stream(3'd3, 16'd0, 0);
    checks++;
    if (w_q.size() != 8 || w_q[0] !== exp_word(0) || n_done != 1) begin
      failures++; $display("FAIL abort_restart got=%0d words want=8 from word 0", w_q.size());
    end
  endtask

  initial begin
    for (int k = 0; k < 21; k++)
      blk1[64*k +: 64] = 64'h0706050403020100 + 64'(k) * 64'h0808080808080808;
    blk2 = blk1 ^ {168{8'hA5}};
    repeat (2) @(negedge clk);
    test_reset();
    test_sha3_256();
    test_sha3_224();
    test_mode_alias();
    test_stall();
    test_shake128();
    test_shake256();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
